sram_1rw_ctrl: RTL
==================

// Module: sram_1rw_ctrl
// PURPOSE
//  Controller for one single-port (1RW) SRAM macro, e.g. 128x5 masked array, read latency 1.
//  Accepts independent read and write request streams and arbitrates them onto the single RW port.
//  Clears the whole array after reset.
//  Holds the last read result stable, because macro rdata is garbage on any cycle with no read.
//  Sits between predictor/metadata logic (upstream) and the *_ext SRAM macro (downstream).
// PARAMETERS
//  SETS        128  number of entries; must be a power of 2
//  WIDTH       5    data width in bits
//  ADDR_W      7    $clog2(SETS); derived, do not override
//  SHOULD_RST  1    1: zero all entries after reset; 0: skip the clear
//  HOLD_READ   1    1: r_resp_data holds the last read; 0: r_resp_data passes sram_rdata through
// PORTS
//  clock         in   1       single clock; also drives the macro RW0_clk
//  reset_n       in   1       asynchronous, active-low reset
//  r_req_valid   in   1       read request
//  r_req_ready   out  1       read request accepted this cycle when valid&&ready
//  r_req_idx     in   ADDR_W  read address
//  r_resp_valid  out  1       one-cycle pulse; read data is valid this cycle
//  r_resp_data   out  WIDTH   read data
//  w_req_valid   in   1       write request
//  w_req_ready   out  1       write request accepted
//  w_req_idx     in   ADDR_W  write address
//  w_req_data    in   WIDTH   write data
//  sram_en       out  1       macro RW0_en
//  sram_wmode    out  1       macro RW0_wmode
//  sram_addr     out  ADDR_W  macro RW0_addr
//  sram_wmask    out  1       macro RW0_wmask; 1 on every write
//  sram_wdata    out  WIDTH   macro RW0_wdata
//  sram_rdata    in   WIDTH   macro RW0_rdata
//  init_done     out  1       array clear complete; requests now accepted
// BEHAVIOUR
//  Reset (asynchronous, any time, including mid-operation) forces:
//   - FSM state INIT, init_cnt=0, rd_pend=0, hold_q=0.
//   - Outputs: init_done=0, both readys=0, r_resp_valid=0, r_resp_data=0, sram_en=0.
//  FSM INIT (SHOULD_RST=1):
//   - Each cycle drives en=1, wmode=1, wmask=1, addr=init_cnt, wdata=0; then init_cnt++.
//   - The write at init_cnt==SETS-1 is the last one; the FSM moves to RUN on the next edge.
//   - The clear takes exactly SETS cycles. Both readys stay 0 throughout.
//  FSM INIT (SHOULD_RST=0): leaves for RUN on the first edge after reset with no writes issued.
//  FSM RUN is terminal until reset.
//   - init_done=1, registered (not decoded from the next state).
//   - w_req_ready=1.
//   - r_req_ready = !w_req_valid, i.e. write has priority on a same-cycle collision.
//  Macro drive in RUN is combinational from the accepted request:
//   - write fire: en=1, wmode=1, wmask=1, addr=w_req_idx, wdata=w_req_data.
//   - read fire:  en=1, wmode=0, addr=r_req_idx.
//   - neither:    en=0. addr and wdata are don't-care; drive 0.
//  Read latency: read fires in cycle T.
//   - rd_pend=1 in cycle T+1, giving r_resp_valid=1 in T+1 only; sram_rdata is sampled in T+1.
//   - r_resp_data = rd_pend ? sram_rdata : hold_q.
//   - hold_q <= sram_rdata at the end of every cycle with rd_pend=1.
//   - HOLD_READ=0: r_resp_data = sram_rdata at all times.
//  Back-to-back reads: one may fire every cycle; responses follow in the same order, 1 cycle later.
//  Write then read of the same address: write in T, read fires in T+1, response in T+2 returns the new data.
//  A read and a write together in one cycle: the write completes. The read retries the next cycle, and the requester holds it.
//  Addresses are ADDR_W wide and wrap naturally; no range check.
//  Requests seen during INIT or during reset are never accepted and never reach the macro.
// STRUCTURE
//  Package sram_ctrl_pkg:
//   - typedef enum logic {ST_INIT, ST_RUN} sram_ctrl_state_e;
//   - localparam for the default SETS and WIDTH.
//  One sub-module: sram_read_hold, holding rd_pend, hold_q and the output mux.
//  The FSM, init counter and arbitration stay in the top module. The macro is instantiated by the parent, not here.
// TESTING
//  1. Release reset -> 128 cycles of en=1, wmode=1, addr 0..127, wdata 0. init_done=1 on the next cycle. A read of 0x55 then returns 0.
//  2. Write 0x1A to addr 3, read addr 3 next cycle -> r_resp_valid pulses 1 cycle later with 0x1A.
//     Then 10 idle cycles with random sram_rdata -> r_resp_data stays 0x1A.
//  3. w_req_valid and r_req_valid together (w idx 9 = 0x07, r idx 9) -> r_req_ready=0 and the write fires.
//     The read fires on the next cycle and returns 0x07.
//  4. Drop reset_n when init_cnt=60 -> outputs clear at once. The clear restarts at addr 0 and runs the full 128 cycles.
//  5. Read requests during INIT -> r_req_ready=0, no read on the macro, r_resp_valid stays 0.
//  6. Reads of addr 127, 0, 127 on consecutive cycles (preloaded 0x11 and 0x02) -> responses 0x11, 0x02, 0x11 on consecutive cycles.

Source files
------------

// File: rtl/sram_1rw_ctrl_pkg.sv
// Shared types and default geometry for the single-port SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic {ST_INIT, ST_RUN} sram_ctrl_state_e;

    localparam int DEF_SETS  = 128;
    localparam int DEF_WIDTH = 5;

endpackage

// File: rtl/sram_1rw_ctrl_if.sv
// Upstream read/write request and read response bundle of the SRAM controller.
interface sram_1rw_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int WIDTH  = 5
) ();
    logic              r_req_valid;
    logic              r_req_ready;
    logic [ADDR_W-1:0] r_req_idx;
    logic              r_resp_valid;
    logic [WIDTH-1:0]  r_resp_data;
    logic              w_req_valid;
    logic              w_req_ready;
    logic [ADDR_W-1:0] w_req_idx;
    logic [WIDTH-1:0]  w_req_data;

    modport slave (
        input  r_req_valid, r_req_idx, w_req_valid, w_req_idx, w_req_data,
        output r_req_ready, r_resp_valid, r_resp_data, w_req_ready
    );

    modport master (
        output r_req_valid, r_req_idx, w_req_valid, w_req_idx, w_req_data,
        input  r_req_ready, r_resp_valid, r_resp_data, w_req_ready
    );
endinterface

// File: rtl/sram_1rw_ctrl_read_hold.sv
// Tracks the one outstanding read and keeps the last read result stable
// while the macro output is undefined.
module sram_read_hold #(
    parameter int WIDTH     = 5,
    parameter int HOLD_READ = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             rd_fire,
    input  logic [WIDTH-1:0] sram_rdata,
    output logic             r_resp_valid,
    output logic [WIDTH-1:0] r_resp_data
);
    logic             rd_pend_q;
    logic [WIDTH-1:0] hold_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            rd_pend_q <= rd_fire;
            if (rd_pend_q) begin
                hold_q <= sram_rdata;
            end
        end
    end

    assign r_resp_valid = rd_pend_q;

    // Macro data is only meaningful in the cycle after a read.
    always_comb begin
        if (HOLD_READ != 0) begin
            r_resp_data = rd_pend_q ? sram_rdata : hold_q;
        end else begin
            r_resp_data = sram_rdata;
        end
    end
endmodule

// File: rtl/sram_1rw_ctrl.sv
// Arbitrates independent read/write streams onto one 1RW SRAM port and clears
// the array after reset.
//   state   | meaning
//   ST_INIT | writing zeros to every entry; requests refused
//   ST_RUN  | normal operation; writes win same-cycle collisions
module sram_1rw_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int SETS       = DEF_SETS,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_W     = $clog2(SETS),
    parameter int SHOULD_RST = 1,
    parameter int HOLD_READ  = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    sram_1rw_ctrl_if.slave    req,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_wmask,
    output logic [WIDTH-1:0]  sram_wdata,
    input  logic [WIDTH-1:0]  sram_rdata,
    output logic              init_done
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SETS - 1);

    sram_ctrl_state_e  state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              init_done_q;
    logic              run;
    logic              w_fire, r_fire;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= (state_d == ST_RUN);
        end
    end

    assign run             = (state_q == ST_RUN);
    assign init_done       = init_done_q;
    assign req.w_req_ready = run;
    assign req.r_req_ready = run && !req.w_req_valid;

    // The clear is gated by reset_n so the macro stays idle while reset is held.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_wmask = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        w_fire     = 1'b0;
        r_fire     = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (SHOULD_RST == 0) begin
                    state_d = ST_RUN;
                end else if (reset_n) begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_wmask = 1'b1;
                    sram_addr  = init_cnt_q;
                    init_cnt_d = init_cnt_q + ADDR_W'(1);
                    if (init_cnt_q == LAST_IDX) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                w_fire = req.w_req_valid;
                r_fire = req.r_req_valid && !req.w_req_valid;
                if (w_fire) begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_wmask = 1'b1;
                    sram_addr  = req.w_req_idx;
                    sram_wdata = req.w_req_data;
                end else if (r_fire) begin
                    sram_en    = 1'b1;
                    sram_addr  = req.r_req_idx;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    sram_read_hold #(
        .WIDTH     (WIDTH),
        .HOLD_READ (HOLD_READ)
    ) u_read_hold (
        .clock        (clock),
        .reset_n      (reset_n),
        .rd_fire      (r_fire),
        .sram_rdata   (sram_rdata),
        .r_resp_valid (req.r_resp_valid),
        .r_resp_data  (req.r_resp_data)
    );
endmodule
